// File: rtl/half_sub_pkg.sv
// Shared constants and helpers for the half-subtractor slice.
package half_sub_pkg;

  localparam int unsigned DefWidth = 1;
  localparam int unsigned DefCntW  = 8;

  // All-ones value of a w-bit counter, clamped to 32 bits.
  function automatic logic [31:0] sat_max(input int unsigned w);
    if (w >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/half_sub_cell.sv
// One-bit combinational half subtractor: a - b.
module half_sub_cell (
  input  logic a_i,
  input  logic b_i,
  output logic diff_o,
  output logic borrow_o
);

  assign diff_o   = a_i ^ b_i;
  assign borrow_o = ~a_i & b_i;

endmodule

// File: rtl/half_sub.sv
// WIDTH independent half-subtractor lanes with a registered copy,
// a valid pipeline stage and a saturating borrow-event counter.
module half_sub
  import half_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] borrow,
  output logic [WIDTH-1:0] diff_q,
  output logic [WIDTH-1:0] borrow_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] borrow_cnt
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(sat_max(CNT_W));

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_sub_cell u_cell (
      .a_i      (a[i]),
      .b_i      (b[i]),
      .diff_o   (diff[i]),
      .borrow_o (borrow[i])
    );
  end

  logic [WIDTH-1:0] diff_d, borrow_d, diff_r, borrow_r;
  logic             out_valid_d, out_valid_r;
  logic [CNT_W-1:0] borrow_cnt_d, borrow_cnt_r;

  always_comb begin
    diff_d       = diff_r;
    borrow_d     = borrow_r;
    out_valid_d  = in_valid;
    borrow_cnt_d = borrow_cnt_r;
    if (in_valid) begin
      diff_d   = diff;
      borrow_d = borrow;
      // Count samples with any lane borrowing; stick at all-ones.
      if ((|borrow) && (borrow_cnt_r != CntMax)) begin
        borrow_cnt_d = borrow_cnt_r + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      diff_r       <= '0;
      borrow_r     <= '0;
      out_valid_r  <= 1'b0;
      borrow_cnt_r <= '0;
    end else begin
      diff_r       <= diff_d;
      borrow_r     <= borrow_d;
      out_valid_r  <= out_valid_d;
      borrow_cnt_r <= borrow_cnt_d;
    end
  end

  assign diff_q     = diff_r;
  assign borrow_q   = borrow_r;
  assign out_valid  = out_valid_r;
  assign borrow_cnt = borrow_cnt_r;

endmodule

// File: tb/tb_half_sub.sv
// Directed bench: a 1-lane/8-bit-counter instance and a 4-lane/2-bit-counter instance.
module tb_half_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       a1, b1;
  logic [3:0] a4, b4;

  logic       diff1, borrow1, diff_q1, borrow_q1, out_valid1;
  logic [7:0] cnt1;
  logic [3:0] diff4, borrow4, diff_q4, borrow_q4;
  logic       out_valid4;
  logic [1:0] cnt4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  half_sub #(.WIDTH(1), .CNT_W(8)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .a          (a1),
    .b          (b1),
    .in_valid   (in_valid),
    .diff       (diff1),
    .borrow     (borrow1),
    .diff_q     (diff_q1),
    .borrow_q   (borrow_q1),
    .out_valid  (out_valid1),
    .borrow_cnt (cnt1)
  );

  half_sub #(.WIDTH(4), .CNT_W(2)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .a          (a4),
    .b          (b4),
    .in_valid   (in_valid),
    .diff       (diff4),
    .borrow     (borrow4),
    .diff_q     (diff_q4),
    .borrow_q   (borrow_q4),
    .out_valid  (out_valid4),
    .borrow_cnt (cnt4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and land 1 ns after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] vec_ab  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [1:0] vec_exp [4] = '{2'b00, 2'b11, 2'b10, 2'b00};  // {diff, borrow}
  logic [1:0] exp_sat [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    rst = 1'b1; in_valid = 1'b0;
    a1 = 1'b0; b1 = 1'b0; a4 = 4'b0; b4 = 4'b0;
    cycle(); cycle();
    check_eq("rst_diff_q1",    32'(diff_q1),    32'd0);
    check_eq("rst_borrow_q1",  32'(borrow_q1),  32'd0);
    check_eq("rst_out_valid1", 32'(out_valid1), 32'd0);
    check_eq("rst_cnt1",       32'(cnt1),       32'd0);
    check_eq("rst_cnt4",       32'(cnt4),       32'd0);
    rst = 1'b0;

    // Combinational truth table, 100 ns per vector, no clocked effects.
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = vec_ab[i];
      #100;
      check_eq($sformatf("tt_diff_%0d", i),   32'(diff1),   32'(vec_exp[i][1]));
      check_eq($sformatf("tt_borrow_%0d", i), 32'(borrow1), 32'(vec_exp[i][0]));
    end
    check_eq("tt_hold_diff_q1", 32'(diff_q1), 32'd0);

    a4 = 4'b0101; b4 = 4'b0011;
    #1;
    check_eq("w4_diff",   32'(diff4),   32'h6);
    check_eq("w4_borrow", 32'(borrow4), 32'h2);

    // Accepted borrowing sample.
    cycle();
    a1 = 1'b0; b1 = 1'b1; a4 = 4'b0000; b4 = 4'b0001; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check_eq("acc_diff_q1",    32'(diff_q1),    32'd1);
    check_eq("acc_borrow_q1",  32'(borrow_q1),  32'd1);
    check_eq("acc_out_valid1", 32'(out_valid1), 32'd1);
    check_eq("acc_cnt1",       32'(cnt1),       32'd1);
    check_eq("acc_diff_q4",    32'(diff_q4),    32'h1);
    check_eq("acc_borrow_q4",  32'(borrow_q4),  32'h1);

    // Idle with toggling inputs: registered values hold.
    a1 = 1'b1; b1 = 1'b0; a4 = 4'b1111; b4 = 4'b0000;
    cycle();
    check_eq("idle_diff_q1",    32'(diff_q1),    32'd1);
    check_eq("idle_borrow_q1",  32'(borrow_q1),  32'd1);
    check_eq("idle_out_valid1", 32'(out_valid1), 32'd0);
    check_eq("idle_cnt1",       32'(cnt1),       32'd1);
    a1 = 1'b1; b1 = 1'b1;
    cycle();
    check_eq("idle2_diff_q1",  32'(diff_q1),   32'd1);
    check_eq("idle2_borrow_q1",32'(borrow_q1), 32'd1);
    check_eq("idle2_diff_q4",  32'(diff_q4),   32'h1);

    // Accepted sample without borrow: load but no count.
    a1 = 1'b1; b1 = 1'b0; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check_eq("nb_diff_q1",   32'(diff_q1),   32'd1);
    check_eq("nb_borrow_q1", 32'(borrow_q1), 32'd0);
    check_eq("nb_cnt1",      32'(cnt1),      32'd1);
    check_eq("nb_diff_q4",   32'(diff_q4),   32'hF);
    check_eq("nb_cnt4",      32'(cnt4),      32'd1);

    // Reset wins over a simultaneous valid borrowing sample.
    rst = 1'b1; in_valid = 1'b1; a1 = 1'b0; b1 = 1'b1; b4 = 4'b1000; a4 = 4'b0000;
    cycle();
    check_eq("rv_diff_q1",    32'(diff_q1),    32'd0);
    check_eq("rv_borrow_q1",  32'(borrow_q1),  32'd0);
    check_eq("rv_out_valid1", 32'(out_valid1), 32'd0);
    check_eq("rv_cnt1",       32'(cnt1),       32'd0);
    check_eq("rv_cnt4",       32'(cnt4),       32'd0);
    check_eq("rv_diff1",      32'(diff1),      32'd1);
    check_eq("rv_borrow1",    32'(borrow1),    32'd1);
    check_eq("rv_borrow4",    32'(borrow4),    32'h8);

    // Saturation of the 2-bit counter; the 8-bit one keeps counting.
    rst = 1'b0; b4 = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq($sformatf("sat_cnt4_%0d", i), 32'(cnt4), 32'(exp_sat[i]));
      check_eq($sformatf("sat_cnt1_%0d", i), 32'(cnt1), 32'(i + 1));
    end
    check_eq("sat_out_valid4", 32'(out_valid4), 32'd1);
    in_valid = 1'b0;
    cycle();
    check_eq("end_out_valid4", 32'(out_valid4), 32'd0);
    check_eq("end_cnt4",       32'(cnt4),       32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/half_sub.md
HALF_SUB -- requirements
Module: half_sub

Interface
REQ-001 Parameter WIDTH, default 1, number of independent 1-bit half-subtractor lanes.
REQ-002 Parameter CNT_W, default 8, width of the borrow-event counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 a  input  WIDTH  minuend, one bit per lane.
REQ-006 b  input  WIDTH  subtrahend, one bit per lane.
REQ-007 in_valid  input  1  qualifies a and b for the registered path.
REQ-008 diff  output  WIDTH  combinational difference per lane.
REQ-009 borrow  output  WIDTH  combinational borrow per lane.
REQ-010 diff_q  output  WIDTH  registered diff.
REQ-011 borrow_q  output  WIDTH  registered borrow.
REQ-012 out_valid  output  1  registered in_valid; qualifies diff_q and borrow_q.
REQ-013 borrow_cnt  output  CNT_W  saturating count of accepted samples with any borrow bit set.

Function
REQ-014 Per lane i: diff[i] SHALL equal a[i] XOR b[i].
REQ-015 Per lane i: borrow[i] SHALL equal (NOT a[i]) AND b[i].
REQ-016 Truth table per lane (a,b -> diff,borrow): 00->0,0; 01->1,1; 10->1,0; 11->0,0.
REQ-017 diff and borrow SHALL be purely combinational, with zero latency and no dependence on clk, rst or in_valid.
REQ-018 Lanes SHALL be independent; no borrow propagates between lanes.
REQ-019 When in_valid=1 at a rising edge, diff_q and borrow_q SHALL load diff and borrow, giving 1-cycle latency.
REQ-020 When in_valid=0, diff_q and borrow_q SHALL hold their previous values.
REQ-021 out_valid SHALL equal in_valid delayed by one cycle.
REQ-022 On an accepted sample (in_valid=1) with borrow nonzero, borrow_cnt SHALL increment by 1.
REQ-023 borrow_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 There is no backpressure; every cycle with in_valid=1 is accepted.

Reset
REQ-025 With rst=1 at a rising edge, diff_q, borrow_q, out_valid and borrow_cnt SHALL all become 0.
REQ-026 rst SHALL take priority over a simultaneous in_valid=1; that sample is discarded and not counted.
REQ-027 rst SHALL NOT affect the combinational diff and borrow outputs.
REQ-028 Reset asserted mid-stream SHALL clear state on the next edge; the first in_valid=1 after release behaves as the first sample after power-up.

Structure
REQ-029 A shared package half_sub_pkg SHALL hold the default WIDTH and CNT_W constants and the saturation max-value function.
REQ-030 A combinational sub-module half_sub_cell (1-bit a, b -> diff, borrow) SHALL be instantiated once per lane.
REQ-031 Registers, valid pipeline and counter SHALL reside in half_sub, in a single clocked process.

Verification
REQ-032 WIDTH=1, apply a,b = 00,01,10,11 at 100 ns steps -> diff/borrow = 0/0, 1/1, 1/0, 0/0, each settling within the step.
REQ-033 in_valid=1 with a=0, b=1 -> one cycle later diff_q=1, borrow_q=1, out_valid=1, borrow_cnt=1.
REQ-034 in_valid=0 while a,b toggle -> diff_q and borrow_q hold, out_valid=0, borrow_cnt unchanged.
REQ-035 CNT_W=2, five accepted a=0, b=1 samples -> borrow_cnt reads 1,2,3,3,3.
REQ-036 rst=1 together with in_valid=1, a=0, b=1 -> next cycle all registered outputs are 0, while diff=1 and borrow=1 remain combinational.
REQ-037 WIDTH=4, a=4'b0101, b=4'b0011 -> diff=4'b0110, borrow=4'b0010.
